// File: rtl/yarp_dmem_responder.sv
// Memory-side responder for the core's load/store port: byte-lane masked word array
// with a fixed wait-state count and a one-cycle response carrying raw right-justified data.
module yarp_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_mem_req_i,
    input  logic [31:0] data_mem_addr_i,
    input  logic [1:0]  data_mem_byte_en_i,
    input  logic        data_mem_wr_i,
    input  logic [31:0] data_mem_wr_data_i,
    output logic        mem_busy_o,
    output logic        mem_rsp_valid_o,
    output logic [31:0] mem_rd_data_o,
    output logic        mem_err_o
);

    localparam int          IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ByteLimit = 33'(64'(DEPTH_WORDS) * 64'd4);
    localparam logic [3:0]  WaitLoad  = 4'(WAIT_CYCLES - 1);
    localparam logic [1:0]  SizeByte  = 2'b00;
    localparam logic [1:0]  SizeHalf  = 2'b01;
    localparam logic [1:0]  SizeWord  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] addr_q;
    logic [1:0]  be_q;
    logic        wr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic            accept;
    logic            enterResp;
    logic [31:0]     curAddr;
    logic [1:0]      curBe;
    logic            curWr;
    logic [31:0]     curWdata;
    logic [1:0]      offset;
    logic [IdxW-1:0] wordIdx;
    logic            accErr;
    logic [3:0]      laneMask;
    logic [31:0]     laneData;
    logic            memWe;
    logic [31:0]     rawWord;
    logic [31:0]     shifted;
    logic [31:0]     loadData;

    assign accept = data_mem_req_i && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (data_mem_req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        count_d = WaitLoad;
                    end
                end
            end
            S_WAIT: begin
                if (count_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the access completes on the accept edge itself,
    // so the request is taken straight from the ports while idle.
    always_comb begin
        curAddr  = (state_q == S_IDLE) ? data_mem_addr_i    : addr_q;
        curBe    = (state_q == S_IDLE) ? data_mem_byte_en_i : be_q;
        curWr    = (state_q == S_IDLE) ? data_mem_wr_i      : wr_q;
        curWdata = (state_q == S_IDLE) ? data_mem_wr_data_i : wdata_q;
        offset   = curAddr[1:0];
        wordIdx  = curAddr[IdxW+1:2];

        accErr = (curBe == 2'b10)
              || ((curBe == SizeHalf) && offset[0])
              || ((curBe == SizeWord) && (offset != 2'b00))
              || ({1'b0, curAddr} >= ByteLimit);

        enterResp = (state_d == S_RESP) && (state_q != S_RESP);

        case (curBe)
            SizeByte: laneMask = 4'b0001 << offset;
            SizeHalf: laneMask = 4'b0011 << offset;
            default:  laneMask = 4'b1111;
        endcase
        laneData = curWdata << {offset, 3'b000};
        memWe    = enterResp && curWr && !accErr;

        rawWord = mem_q[wordIdx];
        shifted = rawWord >> {offset, 3'b000};
        case (curBe)
            SizeByte: loadData = {24'b0, shifted[7:0]};
            SizeHalf: loadData = {16'b0, shifted[15:0]};
            default:  loadData = shifted;
        endcase

        rdata_d = (enterResp && !curWr && !accErr) ? loadData : 32'b0;
        err_d   = enterResp && accErr;
    end

    // reset_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            addr_q  <= 32'b0;
            be_q    <= 2'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q  <= data_mem_addr_i;
                be_q    <= data_mem_byte_en_i;
                wr_q    <= data_mem_wr_i;
                wdata_q <= data_mem_wr_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!reset_n && memWe && laneMask[b]) begin
                mem_q[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
            end
        end
    end

    assign mem_busy_o      = (state_q != S_IDLE);
    assign mem_rsp_valid_o = (state_q == S_RESP);
    assign mem_rd_data_o   = rdata_q;
    assign mem_err_o       = err_q;

endmodule

// File: tb/tb_yarp_dmem_responder.sv
// Scoreboard bench for yarp_dmem_responder: three instances with 1, 2 and 0 wait states
// share the request bus; each has its own request strobe.
module tb_yarp_dmem_responder;

    localparam logic [1:0] SzB   = 2'b00;
    localparam logic [1:0] SzH   = 2'b01;
    localparam logic [1:0] SzW   = 2'b11;
    localparam logic [1:0] SzRsv = 2'b10;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        err;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  reqV;
    logic [31:0] addr;
    logic [1:0]  byteEn;
    logic        wr;
    logic [31:0] wrData;
    logic [2:0]  busyO;
    logic [2:0]  rspValid;
    logic [2:0]  errO;
    logic [31:0] rdData [3];

    exp_t expQ[$];
    int   vectors;
    int   miscompares;

    yarp_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .reset_n(rst), .data_mem_req_i(reqV[0]), .data_mem_addr_i(addr),
        .data_mem_byte_en_i(byteEn), .data_mem_wr_i(wr), .data_mem_wr_data_i(wrData),
        .mem_busy_o(busyO[0]), .mem_rsp_valid_o(rspValid[0]), .mem_rd_data_o(rdData[0]),
        .mem_err_o(errO[0]));

    yarp_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .reset_n(rst), .data_mem_req_i(reqV[1]), .data_mem_addr_i(addr),
        .data_mem_byte_en_i(byteEn), .data_mem_wr_i(wr), .data_mem_wr_data_i(wrData),
        .mem_busy_o(busyO[1]), .mem_rsp_valid_o(rspValid[1]), .mem_rd_data_o(rdData[1]),
        .mem_err_o(errO[1]));

    yarp_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut2 (
        .clk(clk), .reset_n(rst), .data_mem_req_i(reqV[2]), .data_mem_addr_i(addr),
        .data_mem_byte_en_i(byteEn), .data_mem_wr_i(wr), .data_mem_wr_data_i(wrData),
        .mem_busy_o(busyO[2]), .mem_rsp_valid_o(rspValid[2]), .mem_rd_data_o(rdData[2]),
        .mem_err_o(errO[2]));

    // Free-running clock, first rising edge at 5
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int waitOf(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    // Every comparison in the bench funnels through here
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Puts a request on the shared bus for one instance and records the expected response
    task automatic driveReq(input int d, input logic [31:0] a, input logic [1:0] be,
                            input logic w, input logic [31:0] wd,
                            input logic expErr, input logic [31:0] expData, input string tag);
        exp_t e;
        addr    = a;
        byteEn  = be;
        wr      = w;
        wrData  = wd;
        reqV[d] = 1'b1;
        e.dut  = d;
        e.data = expData;
        e.err  = expErr;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    // One complete access: drive, confirm acceptance, measure response latency
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [1:0] be,
                                 input logic w, input logic [31:0] wd,
                                 input logic expErr, input logic [31:0] expData, input string tag);
        int lat;
        @(negedge clk);
        driveReq(d, a, be, w, wd, expErr, expData, tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_acc"}, {31'b0, busyO[d]}, 32'd1);
        reqV[d] = 1'b0;
        lat = 1;
        while (!rspValid[d] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_lat"}, 32'(lat), 32'(waitOf(d) + 1));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop on every response; outside a response the data/error outputs must be zero
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rspValid[d]) begin
                if (expQ.size() == 0 || expQ[0].dut != d) begin
                    checkOutput("spurious_rsp", 32'(d) + 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.tag, "_data"}, rdData[d], e.data);
                    checkOutput({e.tag, "_err"}, {31'b0, errO[d]}, {31'b0, e.err});
                end
            end else begin
                checkOutput("idle_rd", rdData[d], 32'd0);
                checkOutput("idle_err", {31'b0, errO[d]}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int prevBusy;
        int accepts;
        int cyc;
        int lastAcc;
        int busyCnt;
        int guard;

        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        reqV   = 3'b000;
        addr   = 32'b0;
        byteEn = 2'b0;
        wr     = 1'b0;
        wrData = 32'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput("rst_busy", {31'b0, busyO[d]}, 32'd0);
            checkOutput("rst_rsp", {31'b0, rspValid[d]}, 32'd0);
            checkOutput("rst_rd", rdData[d], 32'd0);
            checkOutput("rst_err", {31'b0, errO[d]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic store/load, one wait state");
        applyStimulus(0, 32'h10, SzW, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, "stW10");
        applyStimulus(0, 32'h10, SzW, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, "ldW10");
        applyStimulus(0, 32'h13, SzB, 1'b1, 32'h000000AB, 1'b0, 32'h0, "stB13");
        applyStimulus(0, 32'h10, SzW, 1'b0, 32'h0, 1'b0, 32'hABADBEEF, "ldW10b");
        applyStimulus(0, 32'h12, SzH, 1'b0, 32'h0, 1'b0, 32'h0000ABAD, "ldH12");
        applyStimulus(0, 32'h11, SzB, 1'b0, 32'h0, 1'b0, 32'h000000BE, "ldB11");
        applyStimulus(0, 32'h13, SzB, 1'b0, 32'h0, 1'b0, 32'h000000AB, "ldB13");

        $display("[TB] half store ignores upper data bits");
        applyStimulus(0, 32'h20, SzW, 1'b1, 32'h0, 1'b0, 32'h0, "stW20");
        applyStimulus(0, 32'h22, SzH, 1'b1, 32'h9999C0DE, 1'b0, 32'h0, "stH22");
        applyStimulus(0, 32'h20, SzW, 1'b0, 32'h0, 1'b0, 32'hC0DE0000, "ldW20");

        $display("[TB] error cases");
        applyStimulus(0, 32'h00, SzW, 1'b1, 32'h11223344, 1'b0, 32'h0, "stW00");
        applyStimulus(0, 32'h02, SzW, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0, "stW02err");
        applyStimulus(0, 32'h00, SzW, 1'b0, 32'h0, 1'b0, 32'h11223344, "ldW00");
        applyStimulus(0, 32'h11, SzH, 1'b0, 32'h0, 1'b1, 32'h0, "ldH11err");
        applyStimulus(0, 32'h20, SzRsv, 1'b0, 32'h0, 1'b1, 32'h0, "ldRsv20err");
        applyStimulus(0, 32'h1000, SzW, 1'b0, 32'h0, 1'b1, 32'h0, "ldW1000err");
        applyStimulus(0, 32'hFFC, SzW, 1'b1, 32'h600DF00D, 1'b0, 32'h0, "stWFFC");
        applyStimulus(0, 32'hFFC, SzW, 1'b0, 32'h0, 1'b0, 32'h600DF00D, "ldWFFC");

        $display("[TB] reset during wait aborts the store");
        applyStimulus(0, 32'h40, SzW, 1'b1, 32'h0, 1'b0, 32'h0, "stW40pre");
        @(negedge clk);
        addr    = 32'h40;
        byteEn  = SzW;
        wr      = 1'b1;
        wrData  = 32'h12345678;
        reqV[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstWait_acc", {31'b0, busyO[0]}, 32'd1);
        reqV[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstWait_busy", {31'b0, busyO[0]}, 32'd0);
        checkOutput("rstWait_rsp", {31'b0, rspValid[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(0, 32'h40, SzW, 1'b0, 32'h0, 1'b0, 32'h0, "ldW40");

        $display("[TB] zero wait states");
        applyStimulus(2, 32'h80, SzW, 1'b1, 32'h55AA33CC, 1'b0, 32'h0, "w0stW80");
        applyStimulus(2, 32'h82, SzB, 1'b0, 32'h0, 1'b0, 32'h000000AA, "w0ldB82");
        applyStimulus(2, 32'h80, SzH, 1'b0, 32'h0, 1'b0, 32'h000033CC, "w0ldH80");

        $display("[TB] back-to-back requests, two wait states");
        @(negedge clk);
        driveReq(1, 32'h100, SzW, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0, "b2bStW100");
        prevBusy = 0;
        accepts  = 0;
        cyc      = 0;
        lastAcc  = 0;
        busyCnt  = 0;
        while (accepts < 3 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busyO[1] && prevBusy == 0) begin
                if (accepts > 0) begin
                    checkOutput("b2b_spacing", 32'(cyc - lastAcc), 32'd4);
                    checkOutput("b2b_busyRun", 32'(busyCnt), 32'd3);
                end
                lastAcc = cyc;
                accepts++;
                busyCnt = 0;
                if (accepts == 1) begin
                    void'(expQ.size());
                    driveReq(1, 32'h106, SzH, 1'b1, 32'h0000BEEF, 1'b0, 32'h0, "b2bStH106");
                end else if (accepts == 2) begin
                    driveReq(1, 32'h106, SzH, 1'b0, 32'h0, 1'b0, 32'h0000BEEF, "b2bLdH106");
                end else begin
                    reqV[1] = 1'b0;
                end
            end
            if (busyO[1]) busyCnt++;
            prevBusy = busyO[1] ? 1 : 0;
        end
        reqV[1] = 1'b0;
        checkOutput("b2b_accepts", 32'(accepts), 32'd3);
        guard = 0;
        while (busyO[1] && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
            if (busyO[1]) busyCnt++;
        end
        checkOutput("b2b_lastBusyRun", 32'(busyCnt), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("b2b_drain", 32'(expQ.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/yarp_dmem_responder.md
Name: yarp_dmem_responder

Overview:
Memory-side responder for the core's load/store request interface. Accepts one request (req/addr/byte_en/wr/wr_data) at a time and applies byte-lane masked writes to an internal word array. Returns raw, right-justified read data with a response pulse after a programmable wait-state count. The core-side load unit performs sign/zero extension on the returned data; this block never extends.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words. Byte address space is 0 .. 4*DEPTH_WORDS-1.
WAIT_CYCLES, 1, extra cycles spent in WAIT before the response (0..15 legal).

Ports:
clk  input  1  clock; all state updates on its rising edge
reset_n  input  1  synchronous, active-high reset (port name kept per codebase convention; asserted = 1)
data_mem_req_i  input  1  request valid
data_mem_addr_i  input  32  byte address
data_mem_byte_en_i  input  2  yarp_pkg size: BYTE=2'b00, HALF_WORD=2'b01, WORD=2'b11; 2'b10 is reserved
data_mem_wr_i  input  1  1 = store, 0 = load
data_mem_wr_data_i  input  32  store data, right-justified (byte in [7:0], half in [15:0])
mem_busy_o  output  1  high when a request cannot be accepted
mem_rsp_valid_o  output  1  one-cycle response pulse
mem_rd_data_o  output  32  raw load data, right-justified, upper bits zero
mem_err_o  output  1  error flag for the responding access; valid with rsp_valid

Behaviour:
- Reset (reset_n=1 at an edge):
  - state=IDLE, counter=0.
  - busy_o, rsp_valid_o, rd_data_o and err_o all = 0.
  - Array contents are not reset.
- Accept: req_i=1 and state==IDLE at a rising edge. The block latches addr, byte_en, wr and wr_data. req_i outside IDLE is ignored; the initiator holds req until accepted.
- FSM transitions:
  - IDLE -> WAIT on accept when WAIT_CYCLES>0, loading counter=WAIT_CYCLES-1.
  - IDLE -> RESP on accept when WAIT_CYCLES==0.
  - WAIT: decrement counter. At counter==0 go to RESP.
  - RESP: one cycle, then -> IDLE.
- busy_o = 1 in WAIT and RESP; 0 in IDLE.
- Latency: rsp_valid_o is high exactly WAIT_CYCLES+1 cycles after the accept edge. Maximum throughput is one access per WAIT_CYCLES+2 cycles.
- Outputs outside RESP: rsp_valid_o=0, err_o=0, rd_data_o=0.
- Error check, computed from the latched request:
  - byte_en==2'b10 (reserved);
  - HALF_WORD with addr[0]=1;
  - WORD with addr[1:0]!=0;
  - addr >= 4*DEPTH_WORDS.
  - On error: no array write, rd_data_o=0, err_o=1 in RESP.
- Store:
  - Committed on the edge entering RESP. Word index = addr[31:2]; lane offset = addr[1:0].
  - BYTE writes wr_data[7:0] into lane offset.
  - HALF_WORD writes wr_data[15:0] into lanes offset and offset+1 (offset 0 or 2).
  - WORD writes all four lanes.
  - Other lanes are unchanged.
  - rd_data_o=0 for stores.
- Load:
  - rd_data_o is registered, valid in RESP only.
  - The word at index addr[31:2] is shifted right by 8*addr[1:0].
  - Masked to 8 bits (BYTE), 16 bits (HALF_WORD) or 32 bits (WORD); upper bits are zero.
- Read-after-write: a load accepted after a store's response sees the stored data. Overlap cannot occur because only one access is outstanding.
- Reset mid-operation: reset in WAIT aborts the access; any pending store is not committed, and no response is issued. Reset in RESP: the store was already committed, and outputs go to 0 on the reset edge.
- Simultaneous reset and req: reset wins; the request is not accepted.

Test Plan:
- WAIT_CYCLES=1: store WORD 0xDEADBEEF @0x10, then load WORD @0x10 -> rsp_valid 2 cycles after each accept, rd_data=0xDEADBEEF, err=0.
- Store BYTE 0x000000AB @0x13 after the above; load WORD @0x10 -> 0xABADBEEF. Load HALF @0x12 -> 0x0000ABAD. Load BYTE @0x11 -> 0x000000BE.
- Store WORD @0x02 -> err=1, no write; load WORD @0x00 returns the prior contents. Load HALF @0x11 -> err=1, rd_data=0. byte_en=2'b10 @0x20 -> err=1.
- DEPTH_WORDS=1024: load @0x00001000 -> err=1. Load @0x00000FFC -> err=0.
- Hold req high for 3 back-to-back requests with WAIT_CYCLES=2 -> busy high 3 cycles per access; accepts exactly 4 cycles apart; each response once only.
- Store WORD 0x12345678 @0x40, assert reset_n=1 during WAIT -> no response; the subsequent load @0x40 does not return 0x12345678 (pre-written 0x0 remains); WAIT_CYCLES=0 variant shows rsp_valid 1 cycle after accept.
